seq_key_lock: RTL and testbench
===============================

SEQ_KEY_LOCK -- requirements
Module: seq_key_lock

Interface
REQ-001 Parameter DATA_W, default 8: datapath and output key-gate width (>=2).
REQ-002 Parameter DEPTH, default 2: pipeline stage count (>=1).
REQ-003 Parameter KEY_W, default 4: width of one unlock-sequence word.
REQ-004 Parameter SEQ_LEN, default 3: number of words in the unlock sequence (>=1).
REQ-005 Parameter KEY_SEQ, default 12'h5A3: concatenated unlock words, word 0 in LSBs (default order 0x3, 0xA, 0x5).
REQ-006 Parameter LFSR_SEED, default 8'h01: obfuscation LFSR reset value; nonzero.
REQ-007 Parameter LFSR_TAPS, default 8'hB8: LFSR feedback tap mask.
REQ-008 Parameter GATE_TYPE, default 8'h0F: per-bit output key-gate type, 1=XNOR, 0=XOR.
REQ-009 CK  input  1  sole clock; all state updates on rising edge.
REQ-010 RST  input  1  synchronous, active-high reset.
REQ-011 DIN  input  DATA_W  data entering the pipeline.
REQ-012 DIN_VLD  input  1  DIN qualifier.
REQ-013 KEY_IN  input  KEY_W  unlock-sequence word.
REQ-014 KEY_VLD  input  1  KEY_IN qualifier.
REQ-015 keyinput  input  DATA_W  static key for the output key gates.
REQ-016 DOUT  output  DATA_W  key-gated pipeline output.
REQ-017 DOUT_VLD  output  1  DOUT qualifier.
REQ-018 UNLOCKED  output  1  high while the FSM is in UNLOCKED.
REQ-019 TRAPPED  output  1  high while the FSM is in TRAPPED.

Function
REQ-020 FSM states: LOCKED (index register idx = 0..SEQ_LEN-1), UNLOCKED, TRAPPED.
REQ-021 LOCKED, KEY_VLD=0: state and idx hold.
REQ-022 LOCKED, KEY_VLD=1, KEY_IN == word[idx], idx < SEQ_LEN-1: idx increments.
REQ-023 LOCKED, KEY_VLD=1, KEY_IN == word[SEQ_LEN-1], idx == SEQ_LEN-1: next state is UNLOCKED.
REQ-024 LOCKED, KEY_VLD=1, KEY_IN != word[idx]: next state is TRAPPED.
REQ-025 UNLOCKED and TRAPPED are absorbing. KEY_VLD is ignored in both. Only RST exits them.
REQ-026 UNLOCKED and TRAPPED are registered state decodes. They are never both high.
REQ-027 LFSR (DATA_W bits): next = {lfsr[DATA_W-2:0], parity(lfsr & LFSR_TAPS)}.
REQ-028 The LFSR advances every cycle while the state is not UNLOCKED, and holds while UNLOCKED.
REQ-029 mask = 0 when the current registered state is UNLOCKED; otherwise mask = current LFSR value.
REQ-030 Pipeline of DEPTH data/valid stages, every stage loaded every cycle.
REQ-031 Stage 0 captures DIN and DIN_VLD.
REQ-032 The final stage captures (previous stage data XOR mask). For DEPTH=1, the previous stage is DIN.
REQ-033 Latency is DEPTH cycles from DIN_VLD to DOUT_VLD. There is no backpressure and no bubble squashing.
REQ-034 DOUT[i] = GATE_TYPE[i] ? ~(keyinput[i] ^ core[i]) : (keyinput[i] ^ core[i]), combinational from the final stage register.
REQ-035 The correct static key equals GATE_TYPE. The static key is independent of the FSM, so both locks must be satisfied for plain data.
REQ-036 On the edge where the state becomes UNLOCKED, the final stage still uses the LFSR mask. Zero mask applies from the next edge.

Reset
REQ-037 RST=1 at an edge sets state LOCKED, idx=0, LFSR=LFSR_SEED, all stage data=0, all stage valids=0.
REQ-038 After reset: DOUT_VLD=0, UNLOCKED=0, TRAPPED=0, and DOUT = GATE_TYPE ^ keyinput ^ ... evaluated on core=0 (i.e. DOUT = ~keyinput & GATE_TYPE | keyinput & ~GATE_TYPE).
REQ-039 RST takes priority over KEY_VLD and DIN_VLD in the same cycle.
REQ-040 RST mid-sequence, while UNLOCKED, or while TRAPPED returns the block to the REQ-037 state.

Verification
REQ-041 Locked datapath: reset, keyinput=0x0F, DIN=0x00 with DIN_VLD=1 in the first cycle after reset -> two edges later DOUT=0x02, DOUT_VLD=1, UNLOCKED=0.
REQ-042 Unlock: KEY_IN 0x3, 0xA, 0x5 with KEY_VLD=1 on consecutive cycles -> UNLOCKED=1 after the third edge; then DIN=0x3C, keyinput=0x0F -> DOUT=0x3C two cycles later.
REQ-043 Wrong static key while unlocked: keyinput=0x00, DIN=0x3C -> DOUT=0x33.
REQ-044 Gaps and trap:
- KEY_IN 0x3, then KEY_VLD=0 for 5 cycles, then 0xA, 0x5 -> UNLOCKED=1.
- After reset, KEY_IN 0x3 then 0xB -> TRAPPED=1.
- A subsequent 0x3, 0xA, 0x5 leaves TRAPPED=1, UNLOCKED=0.
REQ-045 Reset mid-operation: assert RST for one cycle while UNLOCKED with DOUT_VLD=1 -> next cycle UNLOCKED=0, DOUT_VLD=0, LFSR=0x01; the locked-datapath check (REQ-041) repeats identically.
REQ-046 Parameter sweep: DATA_W=16, DEPTH=1, SEQ_LEN=1 with a matching nonzero seed and taps -> latency 1 and single-word unlock; the LFSR never reaches 0 over 1000 locked cycles.

Source files
------------

// File: rtl/seq_key_lock.sv
// Sequence-keyed lock: a key-word FSM gates an LFSR obfuscation mask on a data pipeline,
// and a static key on XOR/XNOR gates protects the pipeline output.
module seq_key_lock #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned KEY_W    = 4,
    parameter int unsigned SEQ_LEN  = 3,
    parameter logic [KEY_W*SEQ_LEN-1:0] KEY_SEQ   = (KEY_W*SEQ_LEN)'(12'h5A3),
    parameter logic [DATA_W-1:0]        LFSR_SEED = DATA_W'(8'h01),
    parameter logic [DATA_W-1:0]        LFSR_TAPS = DATA_W'(8'hB8),
    parameter logic [DATA_W-1:0]        GATE_TYPE = DATA_W'(8'h0F)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VLD,
    input  logic [KEY_W-1:0]  KEY_IN,
    input  logic              KEY_VLD,
    input  logic [DATA_W-1:0] keyinput,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VLD,
    output logic              UNLOCKED,
    output logic              TRAPPED
);

    localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_TRAPPED  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [KEY_W-1:0]   cur_word;
    logic [DATA_W-1:0]  lfsr;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  stage_d   [DEPTH];
    logic               stage_v   [DEPTH];
    logic [DATA_W-1:0]  stage_nxt [DEPTH];
    logic               vld_nxt   [DEPTH];

    assign cur_word = KEY_SEQ[KEY_W*int'(idx) +: KEY_W];

    // Unlock sequencer: any wrong word while locked is permanent until reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= ST_LOCKED;
            idx      <= '0;
            UNLOCKED <= 1'b0;
            TRAPPED  <= 1'b0;
        end else if (state == ST_LOCKED && KEY_VLD) begin
            if (KEY_IN == cur_word) begin
                if (idx == LAST_IDX) begin
                    state    <= ST_UNLOCKED;
                    UNLOCKED <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                state   <= ST_TRAPPED;
                TRAPPED <= 1'b1;
            end
        end
    end

    // Obfuscation LFSR freezes once unlocked; mask drops to zero only after the state register flips.
    always_ff @(posedge CK) begin
        if (RST) begin
            lfsr <= LFSR_SEED;
        end else if (state != ST_UNLOCKED) begin
            lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign mask = (state == ST_UNLOCKED) ? '0 : lfsr;

    // Stage inputs; the last stage applies the mask.
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        logic [DATA_W-1:0] src_d;
        logic              src_v;
        if (g == 0) begin : g_first
            assign src_d = DIN;
            assign src_v = DIN_VLD;
        end else begin : g_next
            assign src_d = stage_d[g-1];
            assign src_v = stage_v[g-1];
        end
        if (g == int'(DEPTH) - 1) begin : g_mask
            assign stage_nxt[g] = src_d ^ mask;
        end else begin : g_plain
            assign stage_nxt[g] = src_d;
        end
        assign vld_nxt[g] = src_v;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                stage_d[s] <= '0;
                stage_v[s] <= 1'b0;
            end
        end else begin
            stage_d <= stage_nxt;
            stage_v <= vld_nxt;
        end
    end

    // XNOR bits invert, XOR bits pass: correct static key equals GATE_TYPE.
    assign DOUT     = keyinput ^ stage_d[DEPTH-1] ^ GATE_TYPE;
    assign DOUT_VLD = stage_v[DEPTH-1];

endmodule

// File: tb/tb_seq_key_lock.sv
// Bench for seq_key_lock: directed vector table, random run against a behavioural model,
// and a DATA_W=16 / DEPTH=1 / SEQ_LEN=1 parameter sweep instance.
module tb_seq_key_lock;

    logic       CK = 1'b0;
    logic       RST, DIN_VLD, KEY_VLD;
    logic [7:0] DIN, keyinput, DOUT;
    logic [3:0] KEY_IN;
    logic       DOUT_VLD, UNLOCKED, TRAPPED;

    logic        s_rst, s_din_vld, s_key_vld;
    logic [15:0] s_din, s_keyinput, s_dout;
    logic [3:0]  s_key_in;
    logic        s_dout_vld, s_unlocked, s_trapped;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CK = ~CK;

    seq_key_lock dut (
        .CK(CK), .RST(RST), .DIN(DIN), .DIN_VLD(DIN_VLD), .KEY_IN(KEY_IN), .KEY_VLD(KEY_VLD),
        .keyinput(keyinput), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .UNLOCKED(UNLOCKED), .TRAPPED(TRAPPED)
    );

    seq_key_lock #(
        .DATA_W(16), .DEPTH(1), .KEY_W(4), .SEQ_LEN(1), .KEY_SEQ(4'h7),
        .LFSR_SEED(16'h0001), .LFSR_TAPS(16'hB400), .GATE_TYPE(16'h00FF)
    ) dut16 (
        .CK(CK), .RST(s_rst), .DIN(s_din), .DIN_VLD(s_din_vld), .KEY_IN(s_key_in), .KEY_VLD(s_key_vld),
        .keyinput(s_keyinput), .DOUT(s_dout), .DOUT_VLD(s_dout_vld), .UNLOCKED(s_unlocked), .TRAPPED(s_trapped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        @(negedge CK);
    endtask

    // Plain-arithmetic LFSR step: shift left, feed parity of tapped bits into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic [15:0] taps, input int w);
        logic [15:0] n;
        n = (v << 1) | 16'($countones(v & taps) % 2);
        if (w < 16) n = n & ((16'(1) << w) - 16'(1));
        return n;
    endfunction

    // Behavioural model of the default instance.
    localparam int   M_DEPTH = 2;
    logic [11:0] key_words = 12'h5A3;
    logic [7:0]  m_lfsr, m_core;
    bit          m_vld, m_unl, m_trap;
    int          m_idx;
    logic [7:0]  h_d[$];
    bit          h_v[$];

    task automatic model_reset();
        m_idx = 0; m_unl = 0; m_trap = 0; m_lfsr = 8'h01; m_core = 8'h00; m_vld = 0;
        h_d.delete(); h_v.delete();
        for (int i = 0; i < M_DEPTH - 1; i++) begin
            h_d.push_back(8'h00);
            h_v.push_back(1'b0);
        end
    endtask

    function automatic logic [3:0] word_at(input int i);
        return key_words[4*i +: 4];
    endfunction

    task automatic model_step(input bit rst, input logic [7:0] din, input bit dv, input bit kv, input logic [3:0] k);
        logic [7:0] msk;
        if (rst) begin
            model_reset();
        end else begin
            msk = m_unl ? 8'h00 : m_lfsr;
            h_d.push_back(din);
            h_v.push_back(dv);
            m_core = h_d.pop_front() ^ msk;
            m_vld  = h_v.pop_front();
            if (!m_unl) m_lfsr = 8'(lfsr_step(16'(m_lfsr), 16'h00B8, 8));
            if (kv && !m_unl && !m_trap) begin
                if (k != word_at(m_idx)) m_trap = 1;
                else if (m_idx == 2) m_unl = 1;
                else m_idx++;
            end
        end
    endtask

    typedef struct {
        logic       rst;
        logic       kv;
        logic [3:0] k;
        logic       dv;
        logic [7:0] din;
        logic [7:0] kin;
        logic [7:0] e_dout;
        logic       e_vld;
        logic       e_unl;
        logic       e_trap;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] k, input logic dv,
                                input logic [7:0] din, input logic [7:0] kin, input logic [7:0] e_dout,
                                input logic e_vld, input logic e_unl, input logic e_trap);
        vec_t v;
        v.rst = rst; v.kv = kv; v.k = k; v.dv = dv; v.din = din; v.kin = kin;
        v.e_dout = e_dout; v.e_vld = e_vld; v.e_unl = e_unl; v.e_trap = e_trap;
        return v;
    endfunction

    initial begin
        logic [15:0] m16;
        int          budget;

        RST = 1'b1; DIN = '0; DIN_VLD = 0; KEY_IN = '0; KEY_VLD = 0; keyinput = 8'h0F;
        s_rst = 1'b1; s_din = '0; s_din_vld = 0; s_key_in = '0; s_key_vld = 0; s_keyinput = 16'h00FF;

        //            rst kv  k    dv din    kin    dout   vld unl trap
        tbl[0]  = mk(1, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 0, 4'h0, 1, 8'h00, 8'h0F, 8'h01, 0, 0, 0);
        tbl[2]  = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h02, 1, 0, 0);
        tbl[3]  = mk(0, 1, 4'h3, 0, 8'h00, 8'h0F, 8'h04, 0, 0, 0);
        tbl[4]  = mk(0, 1, 4'hA, 0, 8'h00, 8'h0F, 8'h08, 0, 0, 0);
        tbl[5]  = mk(0, 1, 4'h5, 0, 8'h00, 8'h0F, 8'h11, 0, 1, 0);
        tbl[6]  = mk(0, 0, 4'h0, 1, 8'h3C, 8'h0F, 8'h00, 0, 1, 0);
        tbl[7]  = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h3C, 1, 1, 0);
        tbl[8]  = mk(0, 0, 4'h0, 1, 8'h3C, 8'h00, 8'h0F, 0, 1, 0);
        tbl[9]  = mk(0, 0, 4'h0, 0, 8'h00, 8'h00, 8'h33, 1, 1, 0);
        tbl[10] = mk(0, 0, 4'h0, 1, 8'h3C, 8'h0F, 8'h00, 0, 1, 0);
        tbl[11] = mk(0, 1, 4'hB, 0, 8'h00, 8'h0F, 8'h3C, 1, 1, 0);
        tbl[12] = mk(1, 1, 4'h3, 1, 8'h55, 8'h0F, 8'h00, 0, 0, 0);
        tbl[13] = mk(0, 0, 4'h0, 1, 8'h00, 8'h0F, 8'h01, 0, 0, 0);
        tbl[14] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h02, 1, 0, 0);
        tbl[15] = mk(0, 1, 4'h3, 0, 8'h00, 8'h0F, 8'h04, 0, 0, 0);
        tbl[16] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h08, 0, 0, 0);
        tbl[17] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h11, 0, 0, 0);
        tbl[18] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h23, 0, 0, 0);
        tbl[19] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h47, 0, 0, 0);
        tbl[20] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h8E, 0, 0, 0);
        tbl[21] = mk(0, 1, 4'hA, 0, 8'h00, 8'h0F, 8'h1C, 0, 0, 0);
        tbl[22] = mk(0, 1, 4'h5, 0, 8'h00, 8'h0F, 8'h38, 0, 1, 0);
        tbl[23] = mk(0, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h00, 0, 1, 0);
        tbl[24] = mk(1, 0, 4'h0, 0, 8'h00, 8'h0F, 8'h00, 0, 0, 0);
        tbl[25] = mk(0, 1, 4'h3, 0, 8'h00, 8'h0F, 8'h01, 0, 0, 0);
        tbl[26] = mk(0, 1, 4'hB, 0, 8'h00, 8'h0F, 8'h02, 0, 0, 1);
        tbl[27] = mk(0, 1, 4'h3, 0, 8'h00, 8'h0F, 8'h04, 0, 0, 1);
        tbl[28] = mk(0, 1, 4'hA, 0, 8'h00, 8'h0F, 8'h08, 0, 0, 1);
        tbl[29] = mk(0, 1, 4'h5, 0, 8'h00, 8'h0F, 8'h11, 0, 0, 1);

        for (int i = 0; i < 30; i++) begin
            RST = tbl[i].rst; KEY_VLD = tbl[i].kv; KEY_IN = tbl[i].k;
            DIN_VLD = tbl[i].dv; DIN = tbl[i].din; keyinput = tbl[i].kin;
            tick();
            chk($sformatf("vec%0d dout", i), 32'(DOUT), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d dout_vld", i), 32'(DOUT_VLD), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d unlocked", i), 32'(UNLOCKED), 32'(tbl[i].e_unl));
            chk($sformatf("vec%0d trapped", i), 32'(TRAPPED), 32'(tbl[i].e_trap));
        end

        // Random run against the model; first cycle is a reset.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            RST     = (c == 0) || ($urandom_range(0, 63) == 0);
            KEY_VLD = $urandom_range(0, 1) == 1;
            KEY_IN  = ($urandom_range(0, 3) != 0) ? word_at(m_idx) : 4'($urandom);
            DIN_VLD = $urandom_range(0, 1) == 1;
            DIN     = 8'($urandom);
            keyinput = ($urandom_range(0, 3) != 0) ? 8'h0F : 8'($urandom);
            @(posedge CK);
            model_step(RST, DIN, DIN_VLD, KEY_VLD, KEY_IN);
            @(negedge CK);
            chk("rnd dout", 32'(DOUT), 32'(keyinput ^ m_core ^ 8'h0F));
            chk("rnd dout_vld", 32'(DOUT_VLD), 32'(m_vld));
            chk("rnd unlocked", 32'(UNLOCKED), 32'(m_unl));
            chk("rnd trapped", 32'(TRAPPED), 32'(m_trap));
        end
        RST = 1'b0; KEY_VLD = 0; DIN_VLD = 0;

        // Parameter sweep instance: keyinput equals GATE_TYPE so DOUT shows the core directly.
        s_rst = 1'b1;
        tick();
        chk("p16 reset dout", 32'(s_dout), 32'h0);
        chk("p16 reset vld", 32'(s_dout_vld), 32'h0);
        s_rst = 1'b0; s_din = 16'hBEEF; s_din_vld = 1;
        tick();
        chk("p16 latency1 vld", 32'(s_dout_vld), 32'h1);
        chk("p16 latency1 dout", 32'(s_dout), 32'hBEEE);
        m16 = lfsr_step(16'h0001, 16'hB400, 16);
        s_din = '0; s_din_vld = 0;
        budget = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            chk("p16 lfsr value", 32'(s_dout), 32'(m16));
            if (s_dout == 16'h0) begin
                n_err++;
                $display("FAIL p16 lfsr zero: got 0x0, want nonzero at cycle %0d", c);
            end
            m16 = lfsr_step(m16, 16'hB400, 16);
            budget++;
        end
        chk("p16 locked cycles", 32'(budget), 32'd1000);
        chk("p16 still locked", 32'(s_unlocked), 32'h0);
        s_key_in = 4'h7; s_key_vld = 1;
        tick();
        chk("p16 unlock 1word", 32'(s_unlocked), 32'h1);
        chk("p16 unlock edge mask", 32'(s_dout), 32'(m16));
        s_key_in = 4'h3; s_din = 16'h1234; s_din_vld = 1;
        tick();
        chk("p16 plain dout", 32'(s_dout), 32'h1234);
        chk("p16 no trap after unlock", 32'(s_trapped), 32'h0);
        s_rst = 1'b1; s_key_vld = 0; s_din_vld = 0;
        tick();
        s_rst = 1'b0; s_key_in = 4'h6; s_key_vld = 1;
        tick();
        chk("p16 trap", 32'(s_trapped), 32'h1);
        chk("p16 trap unlocked", 32'(s_unlocked), 32'h0);
        s_key_vld = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
